// File: rtl/trig_prescale_gate_pkg.sv
// Shared types and default widths for the trigger prescale/gate block.
package trig_gate_pkg;

   localparam int NSRC_DEF    = 9;
   localparam int PS_W_DEF    = 8;
   localparam int DEAD_W_DEF  = 8;
   localparam int OUT_LEN_DEF = 4;
   localparam int CNT_W_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      DEAD  = 2'd2
   } gate_state_e;

endpackage

// File: rtl/trig_prescale_gate_if.sv
// Configuration, trigger input and DAQ output bundle of the trigger gate.
// Handshake: none; all signals are levels sampled on every rising clk edge.
interface trig_prescale_gate_if #(
   parameter int NSRC   = trig_gate_pkg::NSRC_DEF,
   parameter int PS_W   = trig_gate_pkg::PS_W_DEF,
   parameter int DEAD_W = trig_gate_pkg::DEAD_W_DEF,
   parameter int CNT_W  = trig_gate_pkg::CNT_W_DEF
);
   import trig_gate_pkg::*;

   logic [NSRC-1:0]      trig_in;
   logic [NSRC-1:0]      src_enable;
   logic [NSRC*PS_W-1:0] prescale;
   logic [DEAD_W-1:0]    dead_cycles;
   logic                 busy_ext;
   logic                 cnt_clear;
   logic                 trig_out;
   logic [NSRC-1:0]      trig_src;
   logic                 gate_busy;
   logic [CNT_W-1:0]     accept_cnt;
   logic [CNT_W-1:0]     veto_cnt;
   gate_state_e          state;

   modport master (
      output trig_in, src_enable, prescale, dead_cycles, busy_ext, cnt_clear,
      input  trig_out, trig_src, gate_busy, accept_cnt, veto_cnt, state
   );

   modport slave (
      input  trig_in, src_enable, prescale, dead_cycles, busy_ext, cnt_clear,
      output trig_out, trig_src, gate_busy, accept_cnt, veto_cnt, state
   );

endinterface

// File: rtl/trig_prescale_gate_prescaler.sv
// One trigger source: two-stage input register, rising-edge detect,
// enable mask and an every-(P+1)th-edge prescale counter.
module trig_prescaler #(
   parameter int PS_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            trig_i,
   input  logic            enable_i,
   input  logic [PS_W-1:0] prescale_i,
   output logic            fire_o
);

   logic            d1_q, d2_q;
   logic [PS_W-1:0] cnt_q, cnt_d;
   logic            rise;
   logic            at_limit;

   assign rise     = d1_q & ~d2_q;
   // >= rather than == so that lowering P mid-count fires on the next edge
   assign at_limit = (cnt_q >= prescale_i);
   assign fire_o   = enable_i & rise & at_limit;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (rise) begin
         cnt_d = at_limit ? '0 : cnt_q + PS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d1_q  <= 1'b0;
         d2_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         d1_q  <= trig_i;
         d2_q  <= d1_q;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/trig_prescale_gate.sv
// Trigger gate: ORs the prescaled source fires, emits a fixed-width DAQ
// pulse followed by a dead time, and keeps saturating accept/veto counts.
module trig_prescale_gate
   import trig_gate_pkg::*;
#(
   parameter int NSRC    = NSRC_DEF,
   parameter int PS_W    = PS_W_DEF,
   parameter int DEAD_W  = DEAD_W_DEF,
   parameter int OUT_LEN = OUT_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input logic                clk,
   input logic                reset,
   trig_prescale_gate_if.slave bus
);

   localparam int OL_W  = $clog2(OUT_LEN + 1);
   localparam int TMR_W = (DEAD_W > OL_W) ? DEAD_W : OL_W;
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(OUT_LEN - 1);

   logic [NSRC-1:0]  fire;
   logic             any_fire;
   gate_state_e      state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [NSRC-1:0]  src_q, src_d;
   logic [CNT_W-1:0] acc_q, acc_d, veto_q, veto_d;
   logic             can_accept, accept, veto;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      trig_prescaler #(.PS_W(PS_W)) u_ps (
         .clk        (clk),
         .reset      (reset),
         .trig_i     (bus.trig_in[i]),
         .enable_i   (bus.src_enable[i]),
         .prescale_i (bus.prescale[i*PS_W +: PS_W]),
         .fire_o     (fire[i])
      );
   end

   assign any_fire = |fire;

   // The last busy cycle may also accept, so back-to-back period is OUT_LEN+dead.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      src_d      = src_q;
      can_accept = 1'b0;
      case (state_q)
         IDLE: can_accept = ~bus.busy_ext;
         PULSE: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else if (bus.dead_cycles == '0) begin
               state_d    = IDLE;
               can_accept = ~bus.busy_ext;
            end else begin
               state_d = DEAD;
               tmr_d   = TMR_W'(bus.dead_cycles) - TMR_W'(1);
            end
         end
         DEAD: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
               state_d    = IDLE;
               can_accept = ~bus.busy_ext;
            end
         end
         default: state_d = IDLE;
      endcase
      accept = any_fire & can_accept;
      veto   = any_fire & ~can_accept;
      if (accept) begin
         state_d = PULSE;
         tmr_d   = PULSE_LAST;
         src_d   = fire;
      end
      acc_d  = acc_q;
      veto_d = veto_q;
      if (bus.cnt_clear) begin
         acc_d  = '0;
         veto_d = '0;
      end else begin
         if (accept && !(&acc_q)) acc_d = acc_q + CNT_W'(1);
         if (veto && !(&veto_q))  veto_d = veto_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         src_q   <= '0;
         acc_q   <= '0;
         veto_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         src_q   <= src_d;
         acc_q   <= acc_d;
         veto_q  <= veto_d;
      end
   end

   assign bus.trig_out   = (state_q == PULSE);
   assign bus.gate_busy  = (state_q != IDLE);
   assign bus.trig_src   = src_q;
   assign bus.accept_cnt = acc_q;
   assign bus.veto_cnt   = veto_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_trig_prescale_gate.sv
// Directed and random checks of trig_prescale_gate against a cycle-count
// reference model (accept time windows, edge counts per source).
module tb_trig_prescale_gate;
  import trig_gate_pkg::*;

  localparam int NSRC    = 9;
  localparam int PS_W    = 8;
  localparam int DEAD_W  = 8;
  localparam int OUT_LEN = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  trig_prescale_gate_if #(.NSRC(NSRC), .PS_W(PS_W), .DEAD_W(DEAD_W), .CNT_W(CNT_W)) bus ();

  trig_prescale_gate #(
    .NSRC(NSRC), .PS_W(PS_W), .DEAD_W(DEAD_W), .OUT_LEN(OUT_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [NSRC-1:0] h1, h2;
  int              edges_since[NSRC];
  longint          cyc;
  longint          last_acc;
  int              dead_at_acc;
  int              m_acc, m_veto;
  logic [NSRC-1:0] m_src;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    h1 = '0;
    h2 = '0;
    for (int i = 0; i < NSRC; i++) edges_since[i] = 0;
    last_acc    = -1000;
    dead_at_acc = 0;
    m_acc       = 0;
    m_veto      = 0;
    m_src       = '0;
  endtask

  function automatic bit model_idle();
    return cyc > last_acc + OUT_LEN + dead_at_acc;
  endfunction

  // One clock: predict from the spec rules, clock the DUT, compare.
  task automatic step();
    logic [NSRC-1:0] rise, fire;
    bit any, ready, in_pulse, in_busy;
    int p;
    rise = h1 & ~h2;
    fire = '0;
    for (int i = 0; i < NSRC; i++) begin
      p = int'(bus.prescale[i*PS_W +: PS_W]);
      if (bus.src_enable[i] && rise[i] && edges_since[i] >= p) fire[i] = 1'b1;
    end
    any   = |fire;
    ready = !bus.busy_ext && (cyc >= last_acc + OUT_LEN + dead_at_acc);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (!bus.src_enable[i]) edges_since[i] = 0;
        else if (rise[i]) edges_since[i] = fire[i] ? 0 : edges_since[i] + 1;
      end
      h2 = h1;
      h1 = bus.trig_in;
      if (any && ready) begin
        last_acc    = cyc;
        m_src       = fire;
        dead_at_acc = int'(bus.dead_cycles);
      end
      if (bus.cnt_clear) begin
        m_acc  = 0;
        m_veto = 0;
      end else begin
        if (any && ready && m_acc < CNT_MAX) m_acc++;
        if (any && !ready && m_veto < CNT_MAX) m_veto++;
      end
    end
    cyc++;
    #1;
    in_pulse = (cyc >= last_acc + 1) && (cyc <= last_acc + OUT_LEN);
    in_busy  = (cyc >= last_acc + 1) && (cyc <= last_acc + OUT_LEN + dead_at_acc);
    chk("trig_out", 32'(bus.trig_out), 32'(in_pulse));
    chk("gate_busy", 32'(bus.gate_busy), 32'(in_busy));
    chk("state", 32'(bus.state), in_pulse ? 32'(PULSE) : (in_busy ? 32'(DEAD) : 32'(IDLE)));
    chk("trig_src", 32'(bus.trig_src), 32'(m_src));
    chk("accept_cnt", 32'(bus.accept_cnt), 32'(m_acc));
    chk("veto_cnt", 32'(bus.veto_cnt), 32'(m_veto));
  endtask

  // driver tasks
  task automatic idle(input int n);
    bus.trig_in = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    bus.trig_in = mask;
    step();
    bus.trig_in = '0;
  endtask

  task automatic clear_cnts();
    bus.cnt_clear = 1'b1;
    step();
    bus.cnt_clear = 1'b0;
  endtask

  task automatic set_ps(input int src, input int p);
    bus.prescale[src*PS_W +: PS_W] = PS_W'(p);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    reset           = 1'b1;
    bus.trig_in     = '0;
    bus.src_enable  = '0;
    bus.prescale    = '0;
    bus.dead_cycles = '0;
    bus.busy_ext    = 1'b0;
    bus.cnt_clear   = 1'b0;
    idle(3);
    chk("rst_trig_out", 32'(bus.trig_out), 32'd0);
    chk("rst_accept", 32'(bus.accept_cnt), 32'd0);
    reset = 1'b0;
    idle(2);

    // single source, P=0: pulse two cycles later, OUT_LEN wide
    bus.src_enable = 9'h001;
    pulse(9'h001);
    step();
    chk("t1_out", 32'(bus.trig_out), 32'd1);
    chk("t1_src", 32'(bus.trig_src), 32'h001);
    idle(8);
    chk("t1_acc", 32'(bus.accept_cnt), 32'd1);

    // P=3 on src4: 8 edges -> 2 accepts
    clear_cnts();
    bus.src_enable = 9'h010;
    set_ps(4, 3);
    for (int k = 0; k < 8; k++) begin
      pulse(9'h010);
      idle(3);
    end
    idle(6);
    chk("t2_acc", 32'(bus.accept_cnt), 32'd2);
    chk("t2_veto", 32'(bus.veto_cnt), 32'd0);

    // dead time 10: edges at 0, 8 (vetoed), 14 (accepted)
    clear_cnts();
    bus.src_enable  = 9'h002;
    bus.dead_cycles = 8'd10;
    for (int t = 0; t < 32; t++) begin
      bus.trig_in = (t == 0 || t == 8 || t == 14) ? 9'h002 : 9'h000;
      step();
    end
    chk("t3_acc", 32'(bus.accept_cnt), 32'd2);
    chk("t3_veto", 32'(bus.veto_cnt), 32'd1);

    // external busy vetoes, then releases
    clear_cnts();
    bus.dead_cycles = 8'd2;
    bus.src_enable  = 9'h004;
    bus.busy_ext    = 1'b1;
    pulse(9'h004);
    idle(4);
    chk("t4_veto", 32'(bus.veto_cnt), 32'd1);
    chk("t4_acc0", 32'(bus.accept_cnt), 32'd0);
    bus.busy_ext = 1'b0;
    pulse(9'h004);
    idle(8);
    chk("t4_acc1", 32'(bus.accept_cnt), 32'd1);

    // simultaneous src0/src8
    clear_cnts();
    bus.src_enable = 9'h101;
    pulse(9'h101);
    idle(8);
    chk("t5_src", 32'(bus.trig_src), 32'h101);
    chk("t5_acc", 32'(bus.accept_cnt), 32'd1);

    // saturation, clear-vs-accept priority, reset mid-pulse
    clear_cnts();
    bus.dead_cycles = 8'd0;
    bus.src_enable  = 9'h001;
    for (int k = 0; k < 17; k++) begin
      pulse(9'h001);
      idle(5);
    end
    chk("t6_sat", 32'(bus.accept_cnt), 32'(CNT_MAX));
    pulse(9'h001);
    bus.cnt_clear = 1'b1;
    step();
    bus.cnt_clear = 1'b0;
    chk("t6_clr_out", 32'(bus.trig_out), 32'd1);
    chk("t6_clr_acc", 32'(bus.accept_cnt), 32'd0);
    idle(6);
    pulse(9'h001);
    idle(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_out", 32'(bus.trig_out), 32'd0);
    chk("t6_rst_state", 32'(bus.state), 32'(IDLE));
    idle(3);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if (k % 60 == 0) begin
        bus.src_enable = NSRC'($urandom);
        for (int i = 0; i < NSRC; i++) set_ps(i, $urandom_range(0, 3));
      end
      if (model_idle() && $urandom_range(0, 15) == 0) bus.dead_cycles = DEAD_W'($urandom_range(0, 6));
      bus.trig_in   = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
      bus.busy_ext  = ($urandom_range(0, 7) == 0);
      bus.cnt_clear = ($urandom_range(0, 63) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset         = 1'b0;
    bus.cnt_clear = 1'b0;
    bus.busy_ext  = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
